// File: rtl/lora_demod_pkg.sv
// Shared constants and state encoding for the IQ demodulator back end.
package lora_demod_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_INTEG = 1'b1
  } integ_state_e;

  localparam int SYM_LEN_DEF    = 2700;
  localparam int FIFO_DEPTH_DEF = 4;

  // Magnitude spans 0..2*sym_len, one bit wider than the ones counter.
  function automatic int mag_width(input int sym_len);
    return $clog2(sym_len + 1) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through head and sticky drop flag.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             ovf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               cnt_q;
  logic                        ovf_q;
  logic                        full, push, pop;

  assign valid_o   = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign pop       = valid_o & rd_en_i;
  // A pop in the same cycle frees the slot the push needs.
  assign push      = wr_en_i & (~full | pop);
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign ovf_o     = ovf_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      if (wr_en_i && full && !pop) ovf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/iq_symbol_integrator.sv
// Integrate-and-dump over 1-bit I/Q streams; slices |I|+|Q| into a symbol bit
// and queues {bit, magnitude} toward the framing logic.
module iq_symbol_integrator
  import lora_demod_pkg::*;
#(
  parameter int SYM_LEN    = SYM_LEN_DEF,
  parameter int THRESH     = SYM_LEN / 2,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int CNT_W     = $clog2(SYM_LEN + 1),
  localparam int MAG_W     = mag_width(SYM_LEN)
) (
  input  logic             clk_27m,
  input  logic             rst,
  input  logic             en,
  input  logic             i_bit,
  input  logic             q_bit,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             sym_bit,
  output logic [MAG_W-1:0] sym_mag,
  output logic             busy,
  output logic             overflow
);
  localparam int AW = CNT_W + 2;

  integ_state_e     state_q, state_d;
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [CNT_W-1:0] ones_i_q, ones_i_d, ones_q_q, ones_q_d;
  logic [CNT_W-1:0] cap_i_q, cap_i_d, cap_q_q, cap_q_d;
  logic             cap_vld_q, cap_vld_d;

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    ones_i_d  = ones_i_q;
    ones_q_d  = ones_q_q;
    cap_i_d   = cap_i_q;
    cap_q_d   = cap_q_q;
    cap_vld_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        samp_d   = '0;
        ones_i_d = '0;
        ones_q_d = '0;
        if (en) state_d = ST_INTEG;
      end
      ST_INTEG: begin
        if (!en) begin
          state_d  = ST_IDLE;
          samp_d   = '0;
          ones_i_d = '0;
          ones_q_d = '0;
        end else if (samp_q == CNT_W'(SYM_LEN - 1)) begin
          // Last sample of the window is folded into the capture directly.
          cap_i_d   = ones_i_q + CNT_W'(i_bit);
          cap_q_d   = ones_q_q + CNT_W'(q_bit);
          cap_vld_d = 1'b1;
          samp_d    = '0;
          ones_i_d  = '0;
          ones_q_d  = '0;
        end else begin
          samp_d   = samp_q + 1'b1;
          ones_i_d = ones_i_q + CNT_W'(i_bit);
          ones_q_d = ones_q_q + CNT_W'(q_bit);
        end
      end
    endcase
  end

  always_ff @(posedge clk_27m) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      samp_q    <= '0;
      ones_i_q  <= '0;
      ones_q_q  <= '0;
      cap_i_q   <= '0;
      cap_q_q   <= '0;
      cap_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      ones_i_q  <= ones_i_d;
      ones_q_q  <= ones_q_d;
      cap_i_q   <= cap_i_d;
      cap_q_q   <= cap_q_d;
      cap_vld_q <= cap_vld_d;
    end
  end

  logic signed [AW-1:0] acc_i, acc_q;
  logic [MAG_W-1:0]     abs_i, abs_q, mag;
  logic                 bit_s;

  assign acc_i = $signed({1'b0, cap_i_q, 1'b0}) - $signed(AW'(SYM_LEN));
  assign acc_q = $signed({1'b0, cap_q_q, 1'b0}) - $signed(AW'(SYM_LEN));
  assign abs_i = acc_i[AW-1] ? MAG_W'(-acc_i) : MAG_W'(acc_i);
  assign abs_q = acc_q[AW-1] ? MAG_W'(-acc_q) : MAG_W'(acc_q);
  assign mag   = abs_i + abs_q;
  assign bit_s = (mag >= MAG_W'(THRESH));

  logic [MAG_W:0] head;

  sync_fifo #(
    .WIDTH (MAG_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_27m),
    .rst       (rst),
    .wr_en_i   (cap_vld_q),
    .wr_data_i ({bit_s, mag}),
    .rd_en_i   (sym_ready),
    .valid_o   (sym_valid),
    .rd_data_o (head),
    .ovf_o     (overflow)
  );

  assign sym_bit = head[MAG_W];
  assign sym_mag = head[MAG_W-1:0];
  assign busy    = (state_q == ST_INTEG);

endmodule

// File: tb/tb_iq_symbol_integrator.sv
// Directed + random bench for iq_symbol_integrator against a window/queue reference model.
module tb_iq_symbol_integrator;
  localparam int SYM_LEN = 8;
  localparam int THRESH  = 4;
  localparam int DEPTH   = 4;

  logic       clk_27m = 1'b0;
  logic       rst = 1'b1, en = 1'b0, i_bit = 1'b0, q_bit = 1'b0, sym_ready = 1'b0;
  logic       sym_valid, sym_bit, busy, overflow;
  logic [4:0] sym_mag;

  iq_symbol_integrator #(
    .SYM_LEN    (SYM_LEN),
    .THRESH     (THRESH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_27m   (clk_27m),
    .rst       (rst),
    .en        (en),
    .i_bit     (i_bit),
    .q_bit     (q_bit),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_bit   (sym_bit),
    .sym_mag   (sym_mag),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk_27m = ~clk_27m;

  typedef struct {
    bit b;
    int mag;
  } sym_t;

  sym_t exp_q[$];
  bit   win_i[$], win_q[$];
  bit   act_m, ovf_m, pend_m;
  sym_t pend_s;
  int   n_chk = 0, n_fail = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check current outputs, then advance the model across the edge.
  task automatic cyc(input bit e, input bit iv, input bit qv, input bit r);
    bit pop;
    int oi, oq;
    en = e; i_bit = iv; q_bit = qv; sym_ready = r;
    chk("sym_valid", sym_valid, exp_q.size() != 0);
    chk("busy", busy, act_m);
    chk("overflow", overflow, ovf_m);
    pop = (exp_q.size() != 0) && r;
    if (pop) begin
      chk("sym_bit", sym_bit, exp_q[0].b);
      chk("sym_mag", sym_mag, exp_q[0].mag);
      void'(exp_q.pop_front());
    end
    if (pend_m) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pend_s);
      else ovf_m = 1'b1;
    end
    pend_m = 1'b0;
    if (!e) begin
      act_m = 1'b0;
      win_i.delete(); win_q.delete();
    end else if (!act_m) begin
      act_m = 1'b1;
    end else begin
      win_i.push_back(iv); win_q.push_back(qv);
      if (win_i.size() == SYM_LEN) begin
        oi = 0; oq = 0;
        foreach (win_i[k]) begin oi += win_i[k]; oq += win_q[k]; end
        pend_s.mag = iabs(2*oi - SYM_LEN) + iabs(2*oq - SYM_LEN);
        pend_s.b   = (pend_s.mag >= THRESH);
        pend_m     = 1'b1;
        win_i.delete(); win_q.delete();
      end
    end
    @(posedge clk_27m); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; i_bit = 1'b0; q_bit = 1'b0; sym_ready = 1'b0;
    @(posedge clk_27m); #1;
    rst = 1'b0;
    exp_q.delete(); win_i.delete(); win_q.delete();
    act_m = 1'b0; ovf_m = 1'b0; pend_m = 1'b0;
    chk("rst_valid", sym_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bit", sym_bit, 0);
    chk("rst_mag", sym_mag, 0);
  endtask

  initial begin
    do_reset();

    // 1: all-ones I, all-zeros Q
    cyc(1, 0, 0, 1);
    for (int k = 0; k < SYM_LEN; k++) cyc(1, 1, 0, 1);
    cyc(1, 0, 1, 1);
    chk("t1_valid", sym_valid, 1);
    chk("t1_mag", sym_mag, 16);
    chk("t1_bit", sym_bit, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);

    // 2: balanced toggling, then threshold edge
    cyc(1, 0, 0, 1);
    for (int k = 0; k < SYM_LEN; k++) cyc(1, (k % 2) == 0, (k % 2) == 0, 1);
    for (int k = 0; k < SYM_LEN; k++) cyc(1, k < 6, (k % 2) == 0, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);

    // 3: five windows into a stalled FIFO
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5*SYM_LEN; k++) cyc(1, 1, k[0], 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1);
    chk("t3_ovf", overflow, 1);
    chk("t3_empty", sym_valid, 0);

    // 4: aborted partial window
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 1, 1);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1);
    chk("t4_busy", busy, 0);
    cyc(1, 0, 0, 1);
    for (int k = 0; k < SYM_LEN; k++) cyc(1, 1'($urandom), 1'($urandom), 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);

    // 5: push onto a full FIFO with a simultaneous pop
    do_reset();
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5*SYM_LEN; k++)
      cyc(1, 1'($urandom), 1'($urandom), pend_m && (exp_q.size() == DEPTH));
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1);
    chk("t5_ovf", overflow, 0);

    // 6: reset in the middle of a window
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 1, 1, 1);
    do_reset();
    cyc(1, 0, 0, 1);
    for (int k = 0; k < SYM_LEN; k++) cyc(1, 1'($urandom), 1'($urandom), 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1);

    // Random traffic with occasional aborts and consumer stalls
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 29) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
